// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial adder sequencer. It drives an external 8-bit adder one byte per cycle,
// starting at the least significant byte, and collects the result into a wide register.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; sum/cout hold the last completed result
// RUN   | one byte per cycle through the external adder, busy=1
// DONE  | one-cycle done pulse, then back to IDLE unconditionally
module byte_serial_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                cin,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_cin,
  input  logic [7:0]          add_sum,
  input  logic                add_cout,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_nxt;

  assign idx_nxt = idx + IW'(1);

  // add_cin doubles as the inter-byte carry register, so it is zero outside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            idx     <= '0;
            add_a   <= a[7:0];
            add_b   <= b[7:0];
            add_cin <= cin;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sum[{idx, 3'b000} +: 8] <= add_sum;
          if (idx == LAST) begin
            idx     <= '0;
            cout    <= add_cout;
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            idx     <= idx_nxt;
            add_a   <= a_q[{idx_nxt, 3'b000} +: 8];
            add_b   <= b_q[{idx_nxt, 3'b000} +: 8];
            add_cin <= add_cout;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Directed bench for byte_serial_add_ctrl (NBYTES=4) with a gate-level 8-bit ripple adder attached.
module tb_byte_serial_add_ctrl;

  localparam int NB = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [8*NB-1:0] a = '0;
  logic [8*NB-1:0] b = '0;
  logic            cin = 1'b0;
  logic [7:0]      add_a, add_b, add_sum;
  logic            add_cin, add_cout;
  logic            busy, done, cout;
  logic [8*NB-1:0] sum;

  int errs = 0;
  int checks = 0;

  byte_serial_add_ctrl #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  wire [8:0] cy;
  assign cy[0] = add_cin;
  for (genvar g = 0; g < 8; g++) begin : g_fa
    assign add_sum[g] = add_a[g] ^ add_b[g] ^ cy[g];
    assign cy[g+1]    = (add_a[g] & add_b[g]) | (cy[g] & (add_a[g] ^ add_b[g]));
  end
  assign add_cout = cy[8];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single start pulse, then per-cycle checks of busy/done and the final result.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic tc, input logic [31:0] es, input logic ec);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_add_a0"}, 64'(add_a), 64'(ta[7:0]));
    check({tag, "_add_b0"}, 64'(add_b), 64'(tb_[7:0]));
    check({tag, "_add_cin0"}, 64'(add_cin), 64'(tc));
    for (int i = 0; i < NB; i++) begin
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_done_early"}, 64'(done), 64'd0);
      @(negedge clk);
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    check({tag, "_sum"}, 64'(sum), 64'(es));
    check({tag, "_cout"}, 64'(cout), 64'(ec));
    check({tag, "_add_a_idle"}, 64'(add_a), 64'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int ndone;
    logic [31:0] dsum;
    int t[$];
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_add", 64'({add_a, add_b, add_cin}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("t1", 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0);
    run_op("t2", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1);
    run_op("t3", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1);
    a = 32'h01010101; b = 32'h02020202; cin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_hold_sum", 64'(sum), 64'hFFFFFFFE);
      check("t3_hold_cout", 64'(cout), 64'd1);
    end

    // start re-pulsed and a changed during RUN cycle 2
    @(negedge clk);
    a = 32'h01020304; b = 32'h10203040; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; dsum = '0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin ndone++; dsum = sum; end
      @(negedge clk);
    end
    check("t4_ndone", 64'(ndone), 64'd1);
    check("t4_sum", 64'(dsum), 64'h11223344);

    // reset in RUN cycle 3
    @(negedge clk);
    a = 32'hAAAAAAAA; b = 32'h55555555; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_sum", 64'(sum), 64'd0);
    check("t5_cout", 64'(cout), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("t5_no_done", 64'(ndone), 64'd0);
    run_op("t5b", 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0);

    // start held high: back-to-back operations
    @(negedge clk);
    a = 32'h00000001; b = 32'h00000002; cin = 1'b0; start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) begin
        t.push_back(c);
        check("t6_sum", 64'(sum), 64'h3);
      end
    end
    start = 1'b0;
    check("t6_npulses_ge3", 64'(t.size() >= 3), 64'd1);
    if (t.size() >= 3) begin
      check("t6_period1", 64'(t[1] - t[0]), 64'(NB + 2));
      check("t6_period2", 64'(t[2] - t[1]), 64'(NB + 2));
    end
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    errs++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1, "timeout");
  end

endmodule
